// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver feeding a one-byte holding register that is
// handed to the command handler over a four-phase request/acknowledge link.
module uart_byte_rx #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic       in_rx_line,
  input  logic       in_rx_enable,
  output logic [7:0] out_data_rx,
  output logic       out_data_rx_hsk_req,
  input  logic       in_data_rx_hsk_ack,
  output logic       out_frame_err,
  output logic       out_overrun
);

  localparam int unsigned CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned BIT_IDX_W = 3;

  // Counter terminal values: half a bit to centre on the start bit, then whole bits.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    R_IDLE  = 3'd0,
    R_START = 3'd1,
    R_DATA  = 3'd2,
    R_STOP  = 3'd3,
    R_BREAK = 3'd4
  } rx_state_t;

  typedef enum logic [1:0] {
    H_IDLE = 2'd0,
    H_REQ  = 2'd1,
    H_ACK  = 2'd2
  } hs_state_t;

  rx_state_t rx_state;
  rx_state_t rx_state_nxt;
  hs_state_t hs_state;
  hs_state_t hs_state_nxt;

  logic                 sync1;
  logic                 rxs;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_IDX_W-1:0] bit_idx;
  logic [DATA_W-1:0]    shreg;
  logic                 full;

  logic cnt_hit;
  logic cnt_clr;
  logic bit_clr;
  logic shift_en;
  logic load;
  logic frame_err_set;
  logic overrun_set;
  logic full_clr;
  logic req_nxt;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= in_rx_line;
      rxs   <= sync1;
    end
  end

  // Sample point detection for the current receive phase.
  always_comb begin
    cnt_hit = 1'b0;
    unique case (rx_state)
      R_START:        cnt_hit = (cnt == HALF_LAST);
      R_DATA, R_STOP: cnt_hit = (cnt == FULL_LAST);
      default:        cnt_hit = 1'b0;
    endcase
  end

  // Receive FSM: state register.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      rx_state <= R_IDLE;
    end else begin
      rx_state <= rx_state_nxt;
    end
  end

  // Receive FSM: next state.
  always_comb begin
    rx_state_nxt = rx_state;
    unique case (rx_state)
      R_IDLE: begin
        if (!rxs) rx_state_nxt = R_START;
      end
      R_START: begin
        if (cnt_hit) rx_state_nxt = rxs ? R_IDLE : R_DATA;
      end
      R_DATA: begin
        if (cnt_hit && (bit_idx == LAST_BIT)) rx_state_nxt = R_STOP;
      end
      R_STOP: begin
        if (cnt_hit) rx_state_nxt = rxs ? R_IDLE : R_BREAK;
      end
      R_BREAK: begin
        if (rxs) rx_state_nxt = R_IDLE;
      end
      default: rx_state_nxt = R_IDLE;
    endcase
  end

  // Receive FSM: datapath controls and stop-bit outcome.
  always_comb begin
    cnt_clr       = 1'b0;
    bit_clr       = 1'b0;
    shift_en      = 1'b0;
    load          = 1'b0;
    frame_err_set = 1'b0;
    overrun_set   = 1'b0;
    unique case (rx_state)
      R_IDLE: begin
        cnt_clr = 1'b1;
        bit_clr = 1'b1;
      end
      R_START: begin
        cnt_clr = cnt_hit;
        bit_clr = 1'b1;
      end
      R_DATA: begin
        cnt_clr  = cnt_hit;
        shift_en = cnt_hit;
      end
      R_STOP: begin
        cnt_clr = cnt_hit;
        if (cnt_hit) begin
          if (!rxs) begin
            frame_err_set = 1'b1;
          end else if (full) begin
            overrun_set = 1'b1;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: begin
        cnt_clr = 1'b1;
        bit_clr = 1'b1;
      end
    endcase
  end

  // Bit timing counter, data bit index and LSB-first shift register.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + CNT_W'(1);
      if (bit_clr) begin
        bit_idx <= '0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + BIT_IDX_W'(1);
      end
      if (shift_en) begin
        shreg <= {rxs, shreg[DATA_W-1:1]};
      end
    end
  end

  // Holding register; out_data_rx keeps the byte until the next load.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      full          <= 1'b0;
      out_data_rx   <= '0;
      out_frame_err <= 1'b0;
      out_overrun   <= 1'b0;
    end else begin
      out_frame_err <= frame_err_set;
      out_overrun   <= overrun_set;
      if (load) begin
        full        <= 1'b1;
        out_data_rx <= shreg;
      end else if (full_clr) begin
        full <= 1'b0;
      end
    end
  end

  // Handshake FSM: state register.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      hs_state <= H_IDLE;
    end else begin
      hs_state <= hs_state_nxt;
    end
  end

  // Handshake FSM: next state. Enable only matters while idle.
  always_comb begin
    hs_state_nxt = hs_state;
    unique case (hs_state)
      H_IDLE: begin
        if (full && in_rx_enable) hs_state_nxt = H_REQ;
      end
      H_REQ: begin
        if (in_data_rx_hsk_ack) hs_state_nxt = H_ACK;
      end
      H_ACK: begin
        if (!in_data_rx_hsk_ack) hs_state_nxt = H_IDLE;
      end
      default: hs_state_nxt = H_IDLE;
    endcase
  end

  // Handshake FSM: outputs. The request is registered from the next state.
  always_comb begin
    full_clr = 1'b0;
    req_nxt  = 1'b0;
    unique case (hs_state)
      H_REQ:   full_clr = in_data_rx_hsk_ack;
      default: full_clr = 1'b0;
    endcase
    req_nxt = (hs_state_nxt == H_REQ);
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      out_data_rx_hsk_req <= 1'b0;
    end else begin
      out_data_rx_hsk_req <= req_nxt;
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx: directed scenarios plus random frames, checked every
// cycle against a timing-formula model of the receiver and handshake.
module tb_uart_byte_rx;

  localparam int CPB  = 8;
  localparam int HALF = CPB / 2;
  localparam int STOP_OFF = HALF + 9 * CPB;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       line = 1'b1;
  logic       en   = 1'b0;
  logic       ack  = 1'b0;
  logic [7:0] data;
  logic       req;
  logic       ferr;
  logic       ovr;

  int checks = 0;
  int errors = 0;

  uart_byte_rx #(.CLKS_PER_BIT(CPB)) dut (
    .in_clk              (clk),
    .in_rst              (rst),
    .in_rx_line          (line),
    .in_rx_enable        (en),
    .out_data_rx         (data),
    .out_data_rx_hsk_req (req),
    .in_data_rx_hsk_ack  (ack),
    .out_frame_err       (ferr),
    .out_overrun         (ovr)
  );

  always #5 clk = ~clk;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is located by its start cycle S and every sample
  // is found by arithmetic on the offset from S.
  bit         m_valid = 1'b0;
  logic       m_d1, m_d2;
  bit         m_busy, m_brk, m_full, m_req, m_wait_low, m_ferr, m_ovr;
  longint     m_t = 0;
  longint     m_s = 0;
  logic [7:0] m_bits, m_data;
  logic [7:0] exp_q[$];

  always @(posedge clk) begin
    logic rx;
    bit   load, clr;
    int   off;
    m_t++;
    if (rst) begin
      m_valid = 1'b1;
      m_d1 = 1'b1; m_d2 = 1'b1;
      m_busy = 0; m_brk = 0; m_full = 0; m_req = 0; m_wait_low = 0;
      m_ferr = 0; m_ovr = 0; m_data = 8'h00; m_bits = 8'h00;
      exp_q.delete();
    end else begin
      rx = m_d2; m_d2 = m_d1; m_d1 = line;
      m_ferr = 0; m_ovr = 0; load = 0;
      if (m_busy) begin
        off = int'(m_t - m_s);
        if (off == HALF) begin
          if (rx) m_busy = 0;
        end else if (off == STOP_OFF) begin
          m_busy = 0;
          if (!rx) begin m_ferr = 1; m_brk = 1; end
          else if (m_full) m_ovr = 1;
          else load = 1;
        end else if (off > HALF && ((off - HALF) % CPB) == 0) begin
          m_bits[(off - HALF) / CPB - 1] = rx;
        end
      end else if (m_brk) begin
        if (rx) m_brk = 0;
      end else if (!rx) begin
        m_busy = 1; m_s = m_t;
      end
      clr = m_req && ack;
      if (m_req) begin
        if (ack) begin m_req = 0; m_wait_low = 1; end
      end else if (m_wait_low) begin
        if (!ack) m_wait_low = 0;
      end else if (m_full && en) begin
        m_req = 1;
      end
      if (load) begin
        m_full = 1; m_data = m_bits; exp_q.push_back(m_bits);
      end else if (clr) begin
        m_full = 0;
      end
    end
  end

  // Per-cycle compare plus event counters for the directed scenarios.
  int   n_req_rise = 0;
  int   n_ferr = 0;
  int   n_ovr = 0;
  logic req_prev = 1'b0;

  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      chk_byte("data", data, m_data);
      chk_bit("req", req, m_req);
      chk_bit("frame_err", ferr, m_ferr);
      chk_bit("overrun", ovr, m_ovr);
      if (req === 1'b1 && req_prev !== 1'b1) n_req_rise++;
      if (ferr === 1'b1) n_ferr++;
      if (ovr === 1'b1) n_ovr++;
      req_prev = req;
    end
  end

  // Handler responder: ack after resp_dly cycles, drop ack resp_dly cycles after req falls.
  bit         resp_on = 1'b0;
  int         resp_dly = 2;
  logic [7:0] last_capt = 8'h00;

  initial begin
    bit got;
    forever begin
      @(negedge clk);
      if (resp_on && req === 1'b1 && ack == 1'b0) begin
        repeat (resp_dly - 1) @(negedge clk);
        ack = 1'b1;
        got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
          @(negedge clk);
          if (req === 1'b0) got = 1;
        end
        checks++;
        if (!got) begin
          errors++;
          $display("FAIL resp_req_fall: req stayed %b, required 0 after ack", req);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL resp_data: got %02h but no byte was expected", data);
        end else begin
          last_capt = data;
          checks--;
          chk_byte("resp_data", data, exp_q.pop_front());
        end
        repeat (resp_dly - 1) @(negedge clk);
        ack = 1'b0;
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop);
    line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      line = b[i];
      repeat (CPB) @(negedge clk);
    end
    line = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic wait_req(input string name, input int budget);
    bit seen;
    seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (req === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: req=0 after %0d cycles, required 1", name, budget);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0, f0, o0;
    logic [7:0] b;
    logic stop;

    // Reset state
    repeat (3) @(negedge clk);
    chk_byte("rst_data", data, 8'h00);
    chk_bit("rst_req", req, 1'b0);
    chk_bit("rst_ferr", ferr, 1'b0);
    chk_bit("rst_ovr", ovr, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 0xA5 with enable high and a responder
    en = 1'b1; resp_on = 1'b1; resp_dly = 2;
    r0 = n_req_rise;
    send_frame(8'hA5, 1'b1);
    line = 1'b1;
    repeat (40) @(negedge clk);
    chk_int("a5_req_count", n_req_rise - r0, 1);
    chk_byte("a5_capt", last_capt, 8'hA5);
    chk_byte("a5_data_held", data, 8'hA5);

    // 0x3C with enable low for 200 cycles
    en = 1'b0;
    r0 = n_req_rise;
    send_frame(8'h3C, 1'b1);
    line = 1'b1;
    repeat (200) @(negedge clk);
    chk_int("3c_req_while_disabled", n_req_rise - r0, 0);
    chk_byte("3c_data_loaded", data, 8'h3C);
    en = 1'b1;
    @(posedge clk); #2;
    chk_bit("3c_req_after_enable", req, 1'b1);
    @(negedge clk);
    repeat (20) @(negedge clk);
    chk_byte("3c_capt", last_capt, 8'h3C);

    // 0x11 unacknowledged, then 0x22 overruns
    resp_on = 1'b0;
    o0 = n_ovr;
    send_frame(8'h11, 1'b1);
    line = 1'b1;
    repeat (10) @(negedge clk);
    chk_bit("ovr_req_pending", req, 1'b1);
    send_frame(8'h22, 1'b1);
    line = 1'b1;
    repeat (10) @(negedge clk);
    chk_int("ovr_pulses", n_ovr - o0, 1);
    chk_byte("ovr_data_kept", data, 8'h11);
    r0 = n_req_rise;
    resp_on = 1'b1;
    repeat (60) @(negedge clk);
    chk_int("ovr_no_second_req", n_req_rise - r0, 0);
    chk_byte("ovr_capt", last_capt, 8'h11);

    // 0x55 with a low stop bit held low, then 0x0F
    f0 = n_ferr; r0 = n_req_rise;
    send_frame(8'h55, 1'b0);
    repeat (30) @(negedge clk);
    line = 1'b1;
    repeat (20) @(negedge clk);
    chk_int("ferr_pulses", n_ferr - f0, 1);
    chk_int("ferr_no_req", n_req_rise - r0, 0);
    send_frame(8'h0F, 1'b1);
    line = 1'b1;
    repeat (40) @(negedge clk);
    chk_int("ferr_next_req", n_req_rise - r0, 1);
    chk_byte("ferr_next_capt", last_capt, 8'h0F);

    // Two-cycle glitch on an idle line
    r0 = n_req_rise; f0 = n_ferr; o0 = n_ovr;
    line = 1'b0;
    repeat (2) @(negedge clk);
    line = 1'b1;
    repeat (100) @(negedge clk);
    chk_int("glitch_req", n_req_rise - r0, 0);
    chk_int("glitch_ferr", n_ferr - f0, 0);
    chk_int("glitch_ovr", n_ovr - o0, 0);

    // Reset during data bit 4, then 0x81
    b = 8'hC3;
    line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      line = b[i];
      repeat (CPB) @(negedge clk);
    end
    line = b[4];
    repeat (HALF) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_byte("midrst_data", data, 8'h00);
    chk_bit("midrst_req", req, 1'b0);
    chk_bit("midrst_ferr", ferr, 1'b0);
    chk_bit("midrst_ovr", ovr, 1'b0);
    rst = 1'b0;
    line = 1'b1;
    repeat (20) @(negedge clk);
    f0 = n_ferr;
    send_frame(8'h81, 1'b1);
    line = 1'b1;
    wait_req("rst_81_req", 20);
    chk_byte("rst_81_data", data, 8'h81);
    repeat (20) @(negedge clk);
    chk_byte("rst_81_capt", last_capt, 8'h81);
    chk_int("rst_no_ferr", n_ferr - f0, 0);

    // Random frames, glitches, stop errors, enable and responder timing
    for (int n = 0; n < 40; n++) begin
      en = ($urandom_range(0, 9) != 0);
      resp_dly = $urandom_range(1, 4);
      if ($urandom_range(0, 4) == 0) begin
        line = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        line = 1'b1;
        repeat (10) @(negedge clk);
      end
      b = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      send_frame(b, stop);
      if (!stop) repeat ($urandom_range(0, 20)) @(negedge clk);
      line = 1'b1;
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    en = 1'b1;
    repeat (200) @(negedge clk);
    chk_int("drain_queue", exp_q.size(), 0);
    chk_bit("drain_req", req, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
